// File: rtl/rotary_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rotary_decoder_if
// Description : Raw encoder pins in, single-cycle rotation/press events out.
// Revision    : 1.0 - initial release
// ============================================================================
interface rotary_decoder_if;
    logic enc_a;
    logic enc_b;
    logic enc_btn;
    logic rotl;
    logic rotr;
    logic push;
    logic glitch;

    modport master (
        output enc_a, enc_b, enc_btn,
        input  rotl, rotr, push, glitch
    );

    modport slave (
        input  enc_a, enc_b, enc_btn,
        output rotl, rotr, push, glitch
    );
endinterface
`default_nettype wire

// File: rtl/rotary_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rotary_decoder
// Description : Synchronise, debounce and decode a quadrature encoder + button
//               into registered single-cycle rotl/rotr/push/glitch events.
// Revision    : 1.0 - initial release
// ============================================================================
module rotary_decoder #(
    parameter int DEBOUNCE = 16,
    parameter int CNT_W    = 5
) (
    input  wire logic       clk,
    input  wire logic       clr,
    rotary_decoder_if.slave enc
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE - 1);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_r1   = 3'd1;
    localparam logic [2:0] c_st_r2   = 3'd2;
    localparam logic [2:0] c_st_r3   = 3'd3;
    localparam logic [2:0] c_st_l1   = 3'd4;
    localparam logic [2:0] c_st_l2   = 3'd5;
    localparam logic [2:0] c_st_l3   = 3'd6;
    localparam logic [2:0] c_st_wait = 3'd7;

    // Pin order: 0 = A, 1 = B, 2 = button; all idle high.
    logic [2:0] w_raw;
    logic [2:0] w_filt;

    assign w_raw = {enc.enc_btn, enc.enc_b, enc.enc_a};

    for (genvar i = 0; i < 3; i++) begin : g_pin
        logic             r_s1;
        logic             r_s2;
        logic             r_filt;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (clr) begin
                r_s1   <= 1'b1;
                r_s2   <= 1'b1;
                r_filt <= 1'b1;
                r_cnt  <= '0;
            end else begin
                r_s1 <= w_raw[i];
                r_s2 <= r_s1;
                // Filtered value follows only after DEBOUNCE consecutive differing samples.
                if (r_s2 == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_filt <= r_s2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_filt[i] = r_filt;
    end

    logic [1:0] w_ab;
    logic       w_btn;
    logic       r_btn_prev;
    logic       w_btn_fall;

    assign w_ab       = {w_filt[0], w_filt[1]};
    assign w_btn      = w_filt[2];
    assign w_btn_fall = r_btn_prev & ~w_btn;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: case (w_ab)
                2'b10:   w_state_nxt = c_st_r1;
                2'b01:   w_state_nxt = c_st_l1;
                2'b00:   w_state_nxt = c_st_wait;
                default: ;
            endcase
            c_st_r1: case (w_ab)
                2'b00:   w_state_nxt = c_st_r2;
                2'b11:   w_state_nxt = c_st_idle;
                2'b01:   w_state_nxt = c_st_wait;
                default: ;
            endcase
            c_st_r2: case (w_ab)
                2'b01:   w_state_nxt = c_st_r3;
                2'b10:   w_state_nxt = c_st_r1;
                2'b11:   w_state_nxt = c_st_wait;
                default: ;
            endcase
            c_st_r3: case (w_ab)
                2'b11:   w_state_nxt = c_st_idle;
                2'b00:   w_state_nxt = c_st_r2;
                2'b10:   w_state_nxt = c_st_wait;
                default: ;
            endcase
            c_st_l1: case (w_ab)
                2'b00:   w_state_nxt = c_st_l2;
                2'b11:   w_state_nxt = c_st_idle;
                2'b10:   w_state_nxt = c_st_wait;
                default: ;
            endcase
            c_st_l2: case (w_ab)
                2'b10:   w_state_nxt = c_st_l3;
                2'b01:   w_state_nxt = c_st_l1;
                2'b11:   w_state_nxt = c_st_wait;
                default: ;
            endcase
            c_st_l3: case (w_ab)
                2'b11:   w_state_nxt = c_st_idle;
                2'b00:   w_state_nxt = c_st_l2;
                2'b01:   w_state_nxt = c_st_wait;
                default: ;
            endcase
            default: begin
                if (w_ab == 2'b11) begin
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    logic w_rotl_evt;
    logic w_rotr_evt;
    logic w_glitch_evt;
    logic w_rot_evt;

    // Any entry into WAIT is caused by a two-bit jump, hence a glitch.
    always_comb begin
        w_rotl_evt   = (r_state == c_st_l3) && (w_ab == 2'b11);
        w_rotr_evt   = (r_state == c_st_r3) && (w_ab == 2'b11);
        w_glitch_evt = (r_state != c_st_wait) && (w_state_nxt == c_st_wait);
        w_rot_evt    = w_rotl_evt | w_rotr_evt;
    end

    logic r_rotl;
    logic r_rotr;
    logic r_push;
    logic r_glitch;
    logic r_push_pend;

    // A press coinciding with a rotation is deferred one cycle behind it.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_rotl      <= 1'b0;
            r_rotr      <= 1'b0;
            r_push      <= 1'b0;
            r_glitch    <= 1'b0;
            r_push_pend <= 1'b0;
            r_btn_prev  <= 1'b1;
        end else begin
            r_rotl      <= w_rotl_evt;
            r_rotr      <= w_rotr_evt;
            r_glitch    <= w_glitch_evt;
            r_push      <= r_push_pend | (w_btn_fall & ~w_rot_evt);
            r_push_pend <= w_btn_fall & w_rot_evt;
            r_btn_prev  <= w_btn;
        end
    end

    assign enc.rotl   = r_rotl;
    assign enc.rotr   = r_rotr;
    assign enc.push   = r_push;
    assign enc.glitch = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_rotary_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotary_decoder
// Description : Directed scoreboard bench for rotary_decoder (DEBOUNCE = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotary_decoder;

    localparam int LAT = 7;

    // Event mask bits / codes: rotl, rotr, push, glitch
    localparam int EV_ROTL   = 1;
    localparam int EV_ROTR   = 2;
    localparam int EV_PUSH   = 4;
    localparam int EV_GLITCH = 8;

    typedef struct packed {
        logic [1:0] code;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   cyc = 0;
    int   t_chg = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [1:0] obs_code;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rotary_decoder_if enc ();

    rotary_decoder #(
        .DEBOUNCE (4),
        .CNT_W    (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .enc (enc)
    );

    always @(negedge clk) begin
        if (enc.rotl | enc.rotr | enc.push | enc.glitch) begin
            obs_code = enc.rotl ? 2'd0 : enc.rotr ? 2'd1 : enc.push ? 2'd2 : 2'd3;
            checks++;
            assert ($countones({enc.rotl, enc.rotr, enc.push, enc.glitch}) == 1)
            else begin
                errors++;
                $error("FAIL onehot cyc=%0d obs=%b required=one-hot", cyc,
                       {enc.rotl, enc.rotr, enc.push, enc.glitch});
            end
            checks++;
            assert (sb.size() > 0)
            else begin
                errors++;
                $error("FAIL unexpected_pulse cyc=%0d obs_code=%0d required=none", cyc, obs_code);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checks++;
                assert (obs_code === mon_e.code && cyc === mon_e.cyc)
                else begin
                    errors++;
                    $error("FAIL event obs_code=%0d obs_cyc=%0d required_code=%0d required_cyc=%0d",
                           obs_code, cyc, mon_e.code, mon_e.cyc);
                end
            end
        end
    end

    task automatic step(input logic a, input logic b, input logic btn, input int hold, input int ev);
        @(negedge clk);
        enc.enc_a   = a;
        enc.enc_b   = b;
        enc.enc_btn = btn;
        t_chg       = cyc;
        for (int c = 0; c < 4; c++) begin
            if (ev[c]) begin
                sb.push_back('{c[1:0],
                               t_chg + LAT + ((c == 2 && (ev & 3) != 0) ? 1 : 0)});
            end
        end
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic check_empty(input string tag);
        checks++;
        assert (sb.size() === 0)
        else begin
            errors++;
            $error("FAIL %s pending=%0d required=0", tag, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        enc.enc_a   = 1'b0;
        enc.enc_b   = 1'b0;
        enc.enc_btn = 1'b0;
        clr         = 1'b1;

        // Reset with all pins low
        repeat (3) begin
            @(negedge clk);
            checks++;
            assert ({enc.rotl, enc.rotr, enc.push, enc.glitch} === 4'b0000)
            else begin
                errors++;
                $error("FAIL reset_outputs obs=%b required=0000",
                       {enc.rotl, enc.rotr, enc.push, enc.glitch});
            end
        end
        @(negedge clk);
        clr         = 1'b0;
        enc.enc_a   = 1'b1;
        enc.enc_b   = 1'b1;
        enc.enc_btn = 1'b1;
        repeat (20) @(negedge clk);
        check_empty("idle_after_reset");

        // Clockwise detent
        step(1'b1, 1'b0, 1'b1, 10, 0);
        step(1'b0, 1'b0, 1'b1, 10, 0);
        step(1'b0, 1'b1, 1'b1, 10, 0);
        step(1'b1, 1'b1, 1'b1, 10, EV_ROTR);
        check_empty("cw");

        // Counter-clockwise, three detents
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 10, 0);
            step(1'b0, 1'b0, 1'b1, 10, 0);
            step(1'b1, 1'b0, 1'b1, 10, 0);
            step(1'b1, 1'b1, 1'b1, 10, EV_ROTL);
            check_empty("ccw");
        end

        // Bouncing A, then a too-short button press
        for (int i = 0; i < 6; i++) begin
            step((i % 2) == 1, 1'b1, 1'b1, 2, 0);
        end
        step(1'b1, 1'b1, 1'b1, 10, 0);
        step(1'b1, 1'b1, 1'b0, 3, 0);
        step(1'b1, 1'b1, 1'b1, 10, 0);
        check_empty("bounce");

        // Illegal jump, then recovery through WAIT
        step(1'b0, 1'b0, 1'b1, 10, EV_GLITCH);
        step(1'b0, 1'b1, 1'b1, 10, 0);
        step(1'b1, 1'b1, 1'b1, 10, 0);
        check_empty("glitch");

        // Reversal mid-sequence
        step(1'b1, 1'b0, 1'b1, 10, 0);
        step(1'b0, 1'b0, 1'b1, 10, 0);
        step(1'b1, 1'b0, 1'b1, 10, 0);
        step(1'b1, 1'b1, 1'b1, 10, 0);
        check_empty("reversal");

        // Reset while parked at 00
        step(1'b1, 1'b0, 1'b1, 10, 0);
        step(1'b0, 1'b0, 1'b1, 10, 0);
        @(negedge clk);
        clr         = 1'b1;
        enc.enc_a   = 1'b1;
        enc.enc_b   = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        repeat (20) @(negedge clk);
        check_empty("clr_mid");

        // Press lands on the same cycle as a CW completion
        step(1'b1, 1'b0, 1'b1, 10, 0);
        step(1'b0, 1'b0, 1'b1, 10, 0);
        step(1'b0, 1'b1, 1'b1, 10, 0);
        step(1'b1, 1'b1, 1'b0, 10, EV_ROTR | EV_PUSH);
        step(1'b1, 1'b1, 1'b1, 10, 0);
        check_empty("collision");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
